// File: rtl/cu_pkg.sv
// Shared definitions for the pipeline control unit: RISC-V major opcodes,
// default register index width, back-end stage indices and a select-width helper.
package cu_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] op_lui    = 7'b0110111;
    localparam logic [6:0] op_auipc  = 7'b0010111;
    localparam logic [6:0] op_jal    = 7'b1101111;
    localparam logic [6:0] op_jalr   = 7'b1100111;
    localparam logic [6:0] op_branch = 7'b1100011;
    localparam logic [6:0] op_load   = 7'b0000011;
    localparam logic [6:0] op_store  = 7'b0100011;
    localparam logic [6:0] op_imm    = 7'b0010011;
    localparam logic [6:0] op_reg    = 7'b0110011;
    localparam logic [6:0] op_fence  = 7'b0001111;
    localparam logic [6:0] op_system = 7'b1110011;

    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    // Width needed to name any of n_stg stages; never narrower than one bit.
    function automatic int sel_w(input int n_stg);
        return (n_stg <= 2) ? 1 : $clog2(n_stg);
    endfunction

endpackage

// File: rtl/cu_scoreboard.sv
// Per-register busy bits for results still owed by long-latency units.
// A write-back in the current cycle is already visible on the read ports.
module cu_scoreboard import cu_pkg::*; #(
    parameter int N_REG = 32,
    parameter int REG_W = cu_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_rd,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy,
    output logic [N_REG-1:0] busy
);

    logic [N_REG-1:0] clr_mask;
    logic [N_REG-1:0] busy_eff;

    always_comb begin
        clr_mask = '0;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
    end

    // The result lands in the register file this cycle, so a reader may issue now.
    assign busy_eff = busy & ~clr_mask;
    assign rs1_busy = busy_eff[rs1];
    assign rs2_busy = busy_eff[rs2];
    assign rd_busy  = busy_eff[rd];

    // Set is applied after clear so a new producer keeps ownership of its rd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy & ~clr_mask;
            if (set_en && set_rd != '0) busy[set_rd] <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: RAW/WAW detection, registered forwarding selects,
// stall/bubble generation and long-latency scoreboard. Macro CU_FORWARD_EN enables forwarding.
module hazard_ctl import cu_pkg::*; #(
    parameter int N_STG = 3,
    parameter int N_REG = 32,
    parameter int REG_W = cu_pkg::REG_W,
    parameter int SEL_W = sel_w(N_STG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_stall,
    input  logic                   amo_req,
    input  logic                   amo_ack,
    input  logic                   id_valid,
    input  logic [REG_W-1:0]       id_rs1,
    input  logic [REG_W-1:0]       id_rs2,
    input  logic                   id_rs1_use,
    input  logic                   id_rs2_use,
    input  logic [REG_W-1:0]       id_rd,
    input  logic                   id_wr,
    input  logic                   id_early,
    input  logic                   id_long,
    input  logic [N_STG-1:0]       stg_valid,
    input  logic [N_STG-1:0]       stg_wr,
    input  logic [N_STG*REG_W-1:0] stg_rd,
    input  logic [N_STG-1:0]       stg_rdy,
    input  logic                   lu_done,
    input  logic [REG_W-1:0]       lu_rd,
    output logic                   stall_fe,
    output logic                   stall_be,
    output logic                   bubble,
    output logic                   a_fw,
    output logic [SEL_W-1:0]       a_sel,
    output logic                   b_fw,
    output logic [SEL_W-1:0]       b_sel,
    output logic [N_REG-1:0]       busy
);

    logic             freeze, haz, waw, a_haz, b_haz, sb_set;
    logic             a_hit, b_hit, a_stg_haz, b_stg_haz;
    logic             rs1_busy, rs2_busy, rd_busy;
    logic [SEL_W-1:0] a_idx, b_idx;

    // Scan oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
        a_hit = 1'b0; a_idx = '0; a_stg_haz = 1'b0;
        b_hit = 1'b0; b_idx = '0; b_stg_haz = 1'b0;
        for (int i = N_STG - 1; i >= 0; i--) begin
            if (stg_valid[i] && stg_wr[i] && id_rs1_use && id_rs1 != '0 &&
                stg_rd[i*REG_W +: REG_W] == id_rs1) begin
                a_hit = 1'b1;
                a_idx = SEL_W'(i);
`ifdef CU_FORWARD_EN
                a_stg_haz = !stg_rdy[i] || (id_early && i != N_STG - 1);
`else
                a_stg_haz = 1'b1;
`endif
            end
            if (stg_valid[i] && stg_wr[i] && id_rs2_use && id_rs2 != '0 &&
                stg_rd[i*REG_W +: REG_W] == id_rs2) begin
                b_hit = 1'b1;
                b_idx = SEL_W'(i);
`ifdef CU_FORWARD_EN
                b_stg_haz = !stg_rdy[i] || (id_early && i != N_STG - 1);
`else
                b_stg_haz = 1'b1;
`endif
            end
        end
    end

    assign freeze = mem_stall | (amo_req & ~amo_ack);
    assign a_haz  = (a_hit & a_stg_haz) | (rs1_busy & id_rs1_use);
    assign b_haz  = (b_hit & b_stg_haz) | (rs2_busy & id_rs2_use);
    assign waw    = id_wr & id_long & rd_busy;
    assign haz    = id_valid & (a_haz | b_haz | waw);

    assign stall_be = rst | freeze;
    assign stall_fe = rst | freeze | haz | amo_req;
    assign bubble   = ~rst & haz & ~freeze;
    assign sb_set   = id_valid & id_long & id_wr & (id_rd != '0) & ~haz & ~freeze;

    // Selects only move when the ID instruction actually advances into EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sel <= '0;
            b_sel <= '0;
        end else if (!freeze && !haz) begin
            if (a_hit) a_sel <= a_idx;
            if (b_hit) b_sel <= b_idx;
        end
    end

`ifdef CU_FORWARD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_fw <= 1'b0;
            b_fw <= 1'b0;
        end else if (!freeze && !haz) begin
            a_fw <= a_hit;
            b_fw <= b_hit;
        end
    end
`else
    logic unused_nofwd;
    assign unused_nofwd = ^{stg_rdy, id_early};
    assign a_fw = 1'b0;
    assign b_fw = 1'b0;
`endif

    cu_scoreboard #(
        .N_REG (N_REG),
        .REG_W (REG_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_rd   (id_rd),
        .clr_en   (lu_done),
        .clr_rd   (lu_rd),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .rd       (id_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .busy     (busy)
    );

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed scenarios plus randomized traffic
// compared against a rule-level reference model. Honours CU_FORWARD_EN.
module tb_hazard_ctl;

    localparam int N_STG = 3;
    localparam int N_REG = 32;
    localparam int REG_W = 5;
    localparam int SEL_W = 2;
`ifdef CU_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_stall, amo_req, amo_ack, id_valid;
    logic [REG_W-1:0] id_rs1, id_rs2, id_rd, lu_rd;
    logic id_rs1_use, id_rs2_use, id_wr, id_early, id_long, lu_done;
    logic [N_STG-1:0] stg_valid, stg_wr, stg_rdy;
    logic [N_STG*REG_W-1:0] stg_rd;
    logic stall_fe, stall_be, bubble, a_fw, b_fw;
    logic [SEL_W-1:0] a_sel, b_sel;
    logic [N_REG-1:0] busy;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    bit [N_REG-1:0] m_busy;
    bit m_afw, m_bfw;
    int m_asel, m_bsel;
    bit e_ahit, e_bhit, e_haz, e_freeze, e_fe, e_be, e_bub;
    int e_aidx, e_bidx;

    hazard_ctl #(.N_STG(N_STG), .N_REG(N_REG), .REG_W(REG_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .amo_req(amo_req), .amo_ack(amo_ack),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use),
        .id_rs2_use(id_rs2_use), .id_rd(id_rd), .id_wr(id_wr), .id_early(id_early),
        .id_long(id_long), .stg_valid(stg_valid), .stg_wr(stg_wr), .stg_rd(stg_rd),
        .stg_rdy(stg_rdy), .lu_done(lu_done), .lu_rd(lu_rd), .stall_fe(stall_fe),
        .stall_be(stall_be), .bubble(bubble), .a_fw(a_fw), .a_sel(a_sel), .b_fw(b_fw),
        .b_sel(b_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_stall = 0; amo_req = 0; amo_ack = 0; id_valid = 0;
        id_rs1 = '0; id_rs2 = '0; id_rs1_use = 0; id_rs2_use = 0;
        id_rd = '0; id_wr = 0; id_early = 0; id_long = 0;
        stg_valid = '0; stg_wr = '0; stg_rd = '0; stg_rdy = '0;
        lu_done = 0; lu_rd = '0;
    endtask

    task automatic set_stage(input int i, input bit v, input bit w, input int rd, input bit rdy);
        stg_valid[i] = v;
        stg_wr[i]    = w;
        stg_rdy[i]   = rdy;
        stg_rd[i*REG_W +: REG_W] = REG_W'(rd);
    endtask

    task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit wr, input bit early, input bit lng);
        id_valid = 1; id_rs1 = REG_W'(rs1); id_rs1_use = u1; id_rs2 = REG_W'(rs2);
        id_rs2_use = u2; id_rd = REG_W'(rd); id_wr = wr; id_early = early; id_long = lng;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cycle();
        rst = 0;
        m_busy = '0; m_afw = 0; m_bfw = 0; m_asel = 0; m_bsel = 0;
    endtask

    // First (youngest) stage producing rs, scanning upward from EX.
    function automatic void scan(input logic [REG_W-1:0] rs, input logic rs_use,
                                 output bit hit, output int idx);
        hit = 0; idx = 0;
        for (int i = 0; i < N_STG; i++) begin
            if (stg_valid[i] && stg_wr[i] && rs_use && rs != 0 &&
                stg_rd[i*REG_W +: REG_W] == rs) begin
                hit = 1; idx = i;
                break;
            end
        end
    endfunction

    function automatic bit owed(input logic [REG_W-1:0] r);
        return m_busy[r] && !(lu_done && lu_rd == r);
    endfunction

    function automatic void model_eval();
        bit ha, hb, waw;
        scan(id_rs1, id_rs1_use, e_ahit, e_aidx);
        scan(id_rs2, id_rs2_use, e_bhit, e_bidx);
        ha = (e_ahit && (!FWD || !stg_rdy[e_aidx] || (id_early && e_aidx != N_STG - 1)))
             || (owed(id_rs1) && id_rs1_use);
        hb = (e_bhit && (!FWD || !stg_rdy[e_bidx] || (id_early && e_bidx != N_STG - 1)))
             || (owed(id_rs2) && id_rs2_use);
        waw = id_wr && id_long && owed(id_rd);
        e_haz    = id_valid && (ha || hb || waw);
        e_freeze = mem_stall || (amo_req && !amo_ack);
        e_be  = e_freeze;
        e_fe  = e_freeze || e_haz || amo_req;
        e_bub = e_haz && !e_freeze;
    endfunction

    function automatic void model_update();
        if (!e_freeze && !e_haz) begin
            m_afw = FWD && e_ahit;
            m_bfw = FWD && e_bhit;
            if (e_ahit) m_asel = e_aidx;
            if (e_bhit) m_bsel = e_bidx;
        end
        if (lu_done) m_busy[lu_rd] = 0;
        if (id_valid && id_long && id_wr && id_rd != 0 && !e_haz && !e_freeze)
            m_busy[id_rd] = 1;
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #3;
        checks++; if (stall_fe !== 1'b1) begin fails++; $display("[TB] FAIL reset_stall_fe: got %b want 1", stall_fe); end
        checks++; if (stall_be !== 1'b1) begin fails++; $display("[TB] FAIL reset_stall_be: got %b want 1", stall_be); end
        checks++; if (bubble !== 1'b0) begin fails++; $display("[TB] FAIL reset_bubble: got %b want 0", bubble); end
        checks++; if ({a_fw, b_fw, a_sel, b_sel} !== 6'b0) begin fails++; $display("[TB] FAIL reset_fwd: got %b%b %0d %0d want 0", a_fw, b_fw, a_sel, b_sel); end
        checks++; if (busy !== '0) begin fails++; $display("[TB] FAIL reset_busy: got %h want 0", busy); end
        cycle();
        rst = 0;
    endtask

    task automatic test_fwd_ex();
        clear_inputs();
        set_stage(0, 1, 1, 5, 1);
        set_id(5, 1, 7, 1, 6, 1, 0, 0);
        #1;
        checks++; if (stall_fe !== !FWD) begin fails++; $display("[TB] FAIL ex_fwd_stall: got %b want %b", stall_fe, !FWD); end
        checks++; if (bubble !== !FWD) begin fails++; $display("[TB] FAIL ex_fwd_bubble: got %b want %b", bubble, !FWD); end
        cycle();
        checks++; if (a_fw !== FWD || a_sel !== 2'd0) begin fails++; $display("[TB] FAIL ex_fwd_a: got %b/%0d want %b/0", a_fw, a_sel, FWD); end
        checks++; if (b_fw !== 1'b0) begin fails++; $display("[TB] FAIL ex_fwd_b: got %b want 0", b_fw); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_stage(0, 1, 1, 5, 0);
        set_id(5, 1, 0, 0, 6, 1, 0, 0);
        #1;
        checks++; if (bubble !== 1'b1) begin fails++; $display("[TB] FAIL load_use_bubble: got %b want 1", bubble); end
        cycle();
        set_stage(0, 0, 0, 0, 0);
        set_stage(1, 1, 1, 5, 1);
        #1;
        checks++; if (bubble !== !FWD) begin fails++; $display("[TB] FAIL load_mem_bubble: got %b want %b", bubble, !FWD); end
        cycle();
        checks++; if (a_fw !== FWD || a_sel !== SEL_W'(FWD ? 1 : 0)) begin fails++; $display("[TB] FAIL load_mem_fwd: got %b/%0d want %b/%0d", a_fw, a_sel, FWD, FWD ? 1 : 0); end
    endtask

    // Producer of x5 walks EX->MEM->WB then leaves; count ID stall cycles.
    task automatic test_producer_walk(input bit early, input int want_stalls, input int want_sel);
        int stalls = 0;
        clear_inputs();
        set_id(5, 1, 0, early, 6, !early, early, 0);
        for (int pos = 0; pos < N_STG; pos++) begin
            stg_valid = '0; stg_wr = '0;
            set_stage(pos, 1, 1, 5, 1);
            #1;
            if (stall_fe) stalls++;
            cycle();
        end
        checks++; if (stalls !== want_stalls) begin fails++; $display("[TB] FAIL walk_stalls_e%0b: got %0d want %0d", early, stalls, want_stalls); end
        checks++; if (a_fw !== (want_stalls < N_STG) || a_sel !== SEL_W'(want_sel)) begin fails++; $display("[TB] FAIL walk_sel_e%0b: got %b/%0d want %b/%0d", early, a_fw, a_sel, want_stalls < N_STG, want_sel); end
        stg_valid = '0;
        #1;
        checks++; if (stall_fe !== 1'b0) begin fails++; $display("[TB] FAIL walk_drained_e%0b: got %b want 0", early, stall_fe); end
    endtask

    task automatic test_x0();
        clear_inputs();
        for (int i = 0; i < N_STG; i++) set_stage(i, 1, 1, 0, 0);
        set_id(0, 1, 0, 1, 6, 1, 1, 0);
        #1;
        checks++; if (stall_fe !== 1'b0) begin fails++; $display("[TB] FAIL x0_stall: got %b want 0", stall_fe); end
        cycle();
        checks++; if (a_fw !== 1'b0 || b_fw !== 1'b0) begin fails++; $display("[TB] FAIL x0_fw: got %b%b want 00", a_fw, b_fw); end
    endtask

    task automatic test_long();
        int stalls = 0;
        clear_inputs();
        set_id(0, 0, 0, 0, 9, 1, 0, 1);
        #1;
        checks++; if (stall_fe !== 1'b0) begin fails++; $display("[TB] FAIL div_issue: got %b want 0", stall_fe); end
        cycle();
        checks++; if (busy !== 32'h0000_0200) begin fails++; $display("[TB] FAIL div_busy: got %h want 00000200", busy); end
        set_id(9, 1, 0, 0, 10, 1, 0, 0);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (stall_fe) stalls++;
            cycle();
        end
        checks++; if (stalls !== 20) begin fails++; $display("[TB] FAIL div_wait: got %0d want 20", stalls); end
        lu_done = 1; lu_rd = 5'd9;
        #1;
        checks++; if (stall_fe !== 1'b0) begin fails++; $display("[TB] FAIL div_done_issue: got %b want 0", stall_fe); end
        cycle();
        checks++; if (busy !== '0) begin fails++; $display("[TB] FAIL div_done_busy: got %h want 0", busy); end
    endtask

    task automatic test_freeze();
        clear_inputs();
        set_id(0, 0, 0, 0, 9, 1, 0, 1);
        cycle();
        mem_stall = 1; lu_done = 1; lu_rd = 5'd9;
        #1;
        checks++; if ({stall_fe, stall_be, bubble} !== 3'b110) begin fails++; $display("[TB] FAIL waw_freeze: got %b want 110", {stall_fe, stall_be, bubble}); end
        cycle();
        checks++; if (busy !== '0) begin fails++; $display("[TB] FAIL freeze_lu_done: got %h want 0", busy); end
        clear_inputs();
        set_stage(1, 1, 1, 5, 1);
        set_id(5, 1, 0, 0, 6, 1, 0, 0);
        cycle();
        set_stage(0, 1, 1, 5, 0);
        set_stage(1, 1, 1, 7, 1);
        set_id(5, 1, 7, 1, 6, 1, 0, 0);
        mem_stall = 1;
        #1;
        checks++; if (bubble !== 1'b0 || stall_fe !== 1'b1) begin fails++; $display("[TB] FAIL freeze_haz: got bub=%b fe=%b want 0/1", bubble, stall_fe); end
        cycle();
        checks++; if (a_fw !== FWD || a_sel !== SEL_W'(FWD ? 1 : 0) || b_fw !== 1'b0) begin fails++; $display("[TB] FAIL freeze_hold: got %b/%0d b=%b want %b/%0d b=0", a_fw, a_sel, b_fw, FWD, FWD ? 1 : 0); end
        clear_inputs();
        amo_req = 1; amo_ack = 1;
        #1;
        checks++; if ({stall_fe, stall_be, bubble} !== 3'b100) begin fails++; $display("[TB] FAIL amo_acked: got %b want 100", {stall_fe, stall_be, bubble}); end
        amo_ack = 0;
        #1;
        checks++; if ({stall_fe, stall_be, bubble} !== 3'b110) begin fails++; $display("[TB] FAIL amo_pending: got %b want 110", {stall_fe, stall_be, bubble}); end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        set_id(0, 0, 0, 0, 9, 1, 0, 1);
        cycle();
        set_stage(0, 1, 1, 3, 1);
        set_id(0, 0, 3, 1, 4, 1, 0, 0);
        cycle();
        checks++; if (b_fw !== FWD) begin fails++; $display("[TB] FAIL pre_rst_fw: got %b want %b", b_fw, FWD); end
        clear_inputs();
        set_id(9, 1, 0, 0, 6, 1, 0, 0);
        #1;
        checks++; if (stall_fe !== 1'b1) begin fails++; $display("[TB] FAIL sb_stall: got %b want 1", stall_fe); end
        #1 rst = 1;
        #1;
        checks++; if (busy !== '0 || a_fw !== 1'b0 || b_fw !== 1'b0) begin fails++; $display("[TB] FAIL async_rst: busy=%h fw=%b%b want 0", busy, a_fw, b_fw); end
        checks++; if (stall_fe !== 1'b1 || bubble !== 1'b0) begin fails++; $display("[TB] FAIL async_rst_out: fe=%b bub=%b want 1/0", stall_fe, bubble); end
        #1 rst = 0;
        #1;
        checks++; if (stall_fe !== 1'b0) begin fails++; $display("[TB] FAIL post_rst_issue: got %b want 0", stall_fe); end
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            mem_stall  = ($urandom % 8) == 0;
            amo_req    = ($urandom % 10) == 0;
            amo_ack    = $urandom % 2;
            id_valid   = ($urandom % 4) != 0;
            id_rs1     = REG_W'($urandom % 4);
            id_rs2     = REG_W'($urandom % 4);
            id_rs1_use = $urandom % 2;
            id_rs2_use = $urandom % 2;
            id_rd      = REG_W'($urandom % 4);
            id_wr      = ($urandom % 3) != 0;
            id_early   = ($urandom % 3) == 0;
            id_long    = ($urandom % 5) == 0;
            for (int i = 0; i < N_STG; i++)
                set_stage(i, ($urandom % 4) != 0, ($urandom % 3) != 0, $urandom % 4, ($urandom % 3) != 0);
            lu_done = ($urandom % 4) == 0;
            lu_rd   = REG_W'($urandom % 4);
            #1;
            model_eval();
            checks++; if ({stall_fe, stall_be, bubble} !== {e_fe, e_be, e_bub}) begin fails++; $display("[TB] FAIL rnd_ctl[%0d]: got %b want %b", n, {stall_fe, stall_be, bubble}, {e_fe, e_be, e_bub}); end
            cycle();
            model_update();
            checks++; if (a_fw !== m_afw || a_sel !== SEL_W'(m_asel)) begin fails++; $display("[TB] FAIL rnd_a[%0d]: got %b/%0d want %b/%0d", n, a_fw, a_sel, m_afw, m_asel); end
            checks++; if (b_fw !== m_bfw || b_sel !== SEL_W'(m_bsel)) begin fails++; $display("[TB] FAIL rnd_b[%0d]: got %b/%0d want %b/%0d", n, b_fw, b_sel, m_bfw, m_bsel); end
            checks++; if (busy !== m_busy) begin fails++; $display("[TB] FAIL rnd_busy[%0d]: got %h want %h", n, busy, m_busy); end
        end
    endtask

    initial begin
        $display("[TB] hazard_ctl bench, forwarding=%0b", FWD);
        test_reset();
        test_fwd_ex();
        do_reset();
        test_load_use();
        do_reset();
        test_producer_walk(1'b1, FWD ? 2 : 3, FWD ? 2 : 0);
        do_reset();
        test_producer_walk(1'b0, FWD ? 0 : 3, FWD ? 2 : 0);
        do_reset();
        test_x0();
        do_reset();
        test_long();
        do_reset();
        test_freeze();
        do_reset();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Parametrised successor to the pipeline control unit.
- Detects RAW/WAW hazards between the ID-stage instruction and N_STG back-end stages.
- Generates registered per-operand forwarding selects, plus front-end stall and EX bubble.
- Tracks long-latency results (mul/div) in a per-register busy scoreboard, so variable-latency units stall only dependent instructions.

Parameters:
- N_STG, 3, number of back-end stages that hold a destination register (index 0 = EX, youngest; N_STG-1 = WB, oldest).
- N_REG, 32, architectural register count; register 0 is hardwired zero.
- REG_W, 5, register index width; must satisfy 2**REG_W >= N_REG.
- SEL_W, 2, forwarding select width; must satisfy 2**SEL_W >= N_STG.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_stall  in  1  imem/dmem miss; freezes everything.
- amo_req  in  1  atomic request pending.
- amo_ack  in  1  atomic acknowledged.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_W  source 1.
- id_rs2  in  REG_W  source 2.
- id_rs1_use  in  1  rs1 read (0 for lui/auipc/jal).
- id_rs2_use  in  1  rs2 read (rtype, branch, store).
- id_rd  in  REG_W  destination.
- id_wr  in  1  ID writes rd.
- id_early  in  1  operand consumed in ID/early EX (branch, jalr, store).
- id_long  in  1  ID instruction goes to a long-latency unit.
- stg_valid  in  N_STG  stage valid.
- stg_wr  in  N_STG  stage writes rd.
- stg_rd  in  N_STG*REG_W  packed rd; stage i occupies bits [i*REG_W +: REG_W].
- stg_rdy  in  N_STG  stage result is final and forwardable (0 for a load in EX).
- lu_done  in  1  long unit writes back this cycle.
- lu_rd  in  REG_W  long unit destination.
- stall_fe  out  1  hold IF/PD/ID.
- stall_be  out  1  hold all back-end stages.
- bubble  out  1  inject NOP into EX this cycle.
- a_fw  out  1  registered: forward operand A.
- a_sel  out  SEL_W  registered: source stage for A.
- b_fw  out  1  registered: forward operand B.
- b_sel  out  SEL_W  registered: source stage for B.
- busy  out  N_REG  scoreboard state (debug/verification).

Behaviour:
- Reset: busy=0, a_fw=b_fw=0, a_sel=b_sel=0. During reset, stall_fe=stall_be=1 and bubble=0.
- freeze = mem_stall | (amo_req & !amo_ack).
- stall_be = freeze.
- Match for operand X (rs1, rs2):
  - Scan stages 0 upward; take the first stage i with stg_valid[i] & stg_wr[i] & stg_rd[i]==rsX & rsX!=0 & rsX_use.
  - Youngest match wins.
- Hazard on X when any of:
  - match exists & !stg_rdy[i]
  - match exists & id_early & i!=N_STG-1
  - busy[rsX] & rsX_use
- WAW hazard: id_wr & id_long & busy[id_rd].
- haz = id_valid & (hazA | hazB | WAW).
- stall_fe = freeze | haz | amo_req.
- bubble = haz & !freeze.
- Forwarding registers update at the clock edge only when !freeze & !haz:
  - a_fw <= matchA exists, a_sel <= i; same for B.
  - With no match: a_fw <= 0 and a_sel holds its value.
- Latency: selects are valid in the cycle the instruction occupies EX (one cycle after ID decode).
- Scoreboard:
  - Set busy[id_rd] when id_valid & id_long & id_wr & id_rd!=0 & !haz & !freeze.
  - Clear busy[lu_rd] on lu_done.
  - lu_done is honoured even under freeze.
  - Set and clear of the same register in the same cycle: set wins (the new producer owns it).
- busy[0] is never set.
- A hazard resolves by itself as stages drain. No counters are needed; re-evaluation happens every cycle.
- Asserting rst mid-stall clears everything immediately; the first instruction after reset sees no hazards.

Optional Feature:
- Macro: CU_FORWARD_EN.
- Defined: forwarding as described above.
- Undefined:
  - Every match is a hazard regardless of stg_rdy.
  - a_fw=b_fw=0 always.
  - The scoreboard is still active.

Decomposition:
- Package cu_pkg holds:
  - opcode constants (op_lui … op_system)
  - REG_W
  - clog2-based SEL_W helper
  - per-stage index constants EX/MEM/WB
- Sub-module cu_scoreboard (N_REG busy bits, set/clear ports, read of rs1/rs2/rd busy).

Test Plan:
- add x5 in EX (rdy=1), ID add x6,x5,x7 -> no stall; next cycle a_fw=1, a_sel=0, b_fw=0.
- ld x5 in EX (rdy=0), ID add uses x5 -> bubble=1 for 1 cycle; after the load moves to MEM with rdy=1: a_fw=1, a_sel=1.
- beq x5 with a producer of x5 in EX -> stall 2 cycles until the producer reaches WB; then a_sel=2, a_fw=1.
- div x9 issued (id_long); ID add uses x9 while lu_done=0 for 20 cycles -> stall_fe=1 for 20 cycles; lu_done with lu_rd=9 -> busy[9]=0 and issue the same cycle.
- Producers of x0 in all stages, ID reads x0 -> no hazard, a_fw=0; mem_stall=1 mid-hazard -> a_sel/b_sel frozen, bubble=0.
- Assert rst during a scoreboard stall -> busy=0, a_fw=b_fw=0 asynchronously; CU_FORWARD_EN undefined with an add->add dependency -> 3-cycle stall.
